// File: rtl/pkt_addr_alloc.sv
// pkt_addr_alloc: ingress buffer-address allocator. Pops addresses from an
// internal circular free list for each accepted header, pushes returned
// addresses back, and hands header plus address to the scheduler as a
// one-cycle enqueue pulse.
module pkt_addr_alloc #(
    parameter int DWIDTH   = 32,
    parameter int NUM_ADDR = 16,
    parameter int HDR_W    = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      ready,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_ugr,
    input  logic [HDR_W-1:0]          in_pkt_info,
    input  logic                      sched_rdy,
    output logic                      out_enque_en,
    output logic                      out_ugr_en,
    output logic [HDR_W-1:0]          out_pkt_info,
    output logic [DWIDTH-1:0]         out_data,
    input  logic                      free_valid,
    input  logic [DWIDTH-1:0]         free_addr,
    output logic [$clog2(NUM_ADDR):0] free_cnt,
    output logic                      free_err
);

    localparam int AW = $clog2(NUM_ADDR);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(NUM_ADDR);
    localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_ADDR - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] mem [NUM_ADDR];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;      // doubles as the init counter k
    logic          init_we;
    logic          init_last;
    logic          alloc;
    logic          push;
    logic          err_set;
    logic          addr_oor;
    logic          mem_we;
    logic [AW-1:0] mem_wdata;

    assign init_last = (wr_ptr == LAST_IDX);
    assign addr_oor  = |(free_addr >> AW);
    assign ready     = (state_q == ST_RUN);

    // Next-state and per-cycle control decode from registered state.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d  = state_q;
        init_we  = 1'b0;
        in_ready = 1'b0;
        alloc    = 1'b0;
        push     = 1'b0;
        err_set  = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_we = 1'b1;
                err_set = free_valid;
                if (init_last) state_d = ST_RUN;
            end
            ST_RUN: begin
                // No same-cycle bypass: an empty list blocks ingress even if a free arrives.
                in_ready = sched_rdy & (free_cnt != '0);
                alloc    = in_valid & in_ready;
                if (free_valid) begin
                    if (free_cnt == FULL_CNT) err_set = 1'b1;
                    else                      push    = 1'b1;
                    if (addr_oor)             err_set = 1'b1;
                end
            end
        endcase
    end

    assign mem_we    = (init_we | push) & ~rst;
    assign mem_wdata = init_we ? wr_ptr : free_addr[AW-1:0];

    // Free-list storage write port (identity fill during init, returns in run).
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; the init sequence rewrites every entry before use.
        if (mem_we) mem[wr_ptr] <= mem_wdata;
    end

    // State, pointers, count, error flag and the registered scheduler outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            state_q      <= ST_INIT;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            free_cnt     <= '0;
            free_err     <= 1'b0;
            out_enque_en <= 1'b0;
            out_ugr_en   <= 1'b0;
            out_data     <= '0;
            out_pkt_info <= '0;
        end else begin
            state_q      <= state_d;
            out_enque_en <= alloc;
            out_ugr_en   <= alloc & in_ugr;
            if (alloc) begin
                out_data     <= DWIDTH'(mem[rd_ptr]);
                out_pkt_info <= in_pkt_info;
                rd_ptr       <= rd_ptr + ONE_PTR;
            end
            if (init_we || push) wr_ptr <= wr_ptr + ONE_PTR;
            if (init_we && init_last)  free_cnt <= FULL_CNT;
            else if (alloc && !push)   free_cnt <= free_cnt - ONE_CNT;
            else if (push && !alloc)   free_cnt <= free_cnt + ONE_CNT;
            if (err_set) free_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pkt_addr_alloc.sv
// tb_pkt_addr_alloc: directed scenarios followed by randomized traffic, all
// compared cycle by cycle against a queue-based model of the free list.
module tb_pkt_addr_alloc;

    localparam int DWIDTH   = 32;
    localparam int NUM_ADDR = 16;
    localparam int HDR_W    = 64;
    localparam int AW       = $clog2(NUM_ADDR);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ready;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_ugr = 1'b0;
    logic [HDR_W-1:0]  in_pkt_info = '0;
    logic              sched_rdy = 1'b0;
    logic              out_enque_en;
    logic              out_ugr_en;
    logic [HDR_W-1:0]  out_pkt_info;
    logic [DWIDTH-1:0] out_data;
    logic              free_valid = 1'b0;
    logic [DWIDTH-1:0] free_addr = '0;
    logic [AW:0]       free_cnt;
    logic              free_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    bit               m_valid = 0;
    int               m_init_left;
    int               m_q[$];
    int               m_held[$];
    bit               m_err;
    bit               m_pulse;
    bit               m_ugr;
    logic [DWIDTH-1:0] m_data;
    logic [HDR_W-1:0] m_info;

    always #5 clk = ~clk;

    pkt_addr_alloc #(.DWIDTH(DWIDTH), .NUM_ADDR(NUM_ADDR), .HDR_W(HDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .ready        (ready),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_ugr       (in_ugr),
        .in_pkt_info  (in_pkt_info),
        .sched_rdy    (sched_rdy),
        .out_enque_en (out_enque_en),
        .out_ugr_en   (out_ugr_en),
        .out_pkt_info (out_pkt_info),
        .out_data     (out_data),
        .free_valid   (free_valid),
        .free_addr    (free_addr),
        .free_cnt     (free_cnt),
        .free_err     (free_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_running();
        return m_valid && (m_init_left == 0);
    endfunction

    // Advance the model by one clock edge using the inputs applied this cycle.
    task automatic model_step(input bit r, input bit iv, input bit ug, input logic [HDR_W-1:0] info,
                              input bit sr, input bit fv, input logic [DWIDTH-1:0] fa);
        bit alloc;
        bit full;
        if (r) begin
            m_valid     = 1;
            m_init_left = NUM_ADDR;
            m_q.delete();
            m_held.delete();
            m_err   = 0;
            m_pulse = 0;
            m_ugr   = 0;
            m_data  = '0;
            m_info  = '0;
        end else if (!m_valid) begin
            // nothing known before the first reset
        end else if (m_init_left > 0) begin
            if (fv) m_err = 1;
            m_pulse = 0;
            m_ugr   = 0;
            m_init_left--;
            if (m_init_left == 0)
                for (int i = 0; i < NUM_ADDR; i++) m_q.push_back(i);
        end else begin
            alloc   = iv && sr && (m_q.size() != 0);
            full    = (m_q.size() == NUM_ADDR);
            m_pulse = alloc;
            m_ugr   = alloc && ug;
            if (alloc) begin
                m_data = DWIDTH'(m_q.pop_front());
                m_info = info;
                m_held.push_back(int'(m_data));
            end
            if (fv) begin
                if (full) m_err = 1;
                else      m_q.push_back(int'(fa % NUM_ADDR));
                if (fa >= NUM_ADDR) m_err = 1;
            end
        end
    endtask

    // One clock cycle: drive inputs, check in_ready, clock, check registered outputs.
    task automatic cycle(input bit r, input bit iv, input bit ug, input logic [HDR_W-1:0] info,
                         input bit sr, input bit fv, input logic [DWIDTH-1:0] fa);
        rst         = r;
        in_valid    = iv;
        in_ugr      = ug;
        in_pkt_info = info;
        sched_rdy   = sr;
        free_valid  = fv;
        free_addr   = fa;
        #1;
        if (m_valid)
            check("in_ready", in_ready, model_running() && sr && (m_q.size() != 0));
        @(posedge clk);
        model_step(r, iv, ug, info, sr, fv, fa);
        @(negedge clk);
        if (m_valid) begin
            check("ready", ready, model_running());
            check("free_cnt", free_cnt, model_running() ? m_q.size() : 0);
            check("free_err", free_err, m_err);
            check("out_enque_en", out_enque_en, m_pulse);
            check("out_ugr_en", out_ugr_en, m_ugr);
            check("out_data", out_data, m_data);
            check("out_pkt_info", out_pkt_info, m_info);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, 1, 0, '0);
    endtask

    task automatic alloc_n(input int n, input bit ug);
        for (int i = 0; i < n; i++) cycle(0, 1, ug, {$urandom, $urandom}, 1, 0, '0);
    endtask

    task automatic free_one(input logic [DWIDTH-1:0] a);
        cycle(0, 0, 0, '0, 1, 1, a);
    endtask

    initial begin
        bit               r, fv;
        int               idx;
        logic [DWIDTH-1:0] fa;

        // Reset and init: ready low for 16 edges, then high with a full list.
        repeat (3) cycle(1, 0, 0, '0, 1, 0, '0);
        idle(15);
        check("init_not_ready", ready, 1'b0);
        idle(1);
        check("init_ready", ready, 1'b1);
        check("init_cnt", free_cnt, NUM_ADDR);

        // Free while full is an error, sticky, and leaves the count alone.
        free_one(5);
        idle(2);
        check("overflow_err_sticky", free_err, 1'b1);
        check("overflow_cnt", free_cnt, NUM_ADDR);

        // Drain all addresses back to back, then confirm ingress is blocked.
        alloc_n(NUM_ADDR, 0);
        alloc_n(2, 0);
        check("drain_empty", free_cnt, 0);

        // Recycle in FIFO order.
        free_one(7);
        free_one(3);
        alloc_n(2, 0);
        check("recycle_empty", free_cnt, 0);

        // Simultaneous allocate and free at count 4.
        free_one(10); free_one(11); free_one(12); free_one(13);
        cycle(0, 1, 0, {$urandom, $urandom}, 1, 1, 9);
        check("simul_cnt", free_cnt, 4);
        alloc_n(4, 0);
        check("simul_last", out_data, 9);

        // Backpressure: scheduler not ready blocks the accept.
        free_one(1); free_one(2);
        repeat (3) cycle(0, 1, 0, {$urandom, $urandom}, 0, 0, '0);
        check("bp_cnt", free_cnt, 2);

        // Urgent packet consumes an address.
        alloc_n(1, 1);
        check("urgent_flag", out_ugr_en, 1'b1);

        // Out-of-range return: error set, low bits still pushed.
        cycle(1, 0, 0, '0, 1, 0, '0);
        idle(NUM_ADDR);
        alloc_n(1, 0);
        cycle(0, 0, 0, '0, 1, 1, 32'h0000_0130);
        check("oor_err", free_err, 1'b1);

        // Mid-run reset with a free during init; first allocation is address 0.
        alloc_n(5, 0);
        cycle(1, 0, 0, '0, 1, 0, '0);
        cycle(0, 0, 0, '0, 1, 1, 4);
        check("init_free_err", free_err, 1'b1);
        idle(NUM_ADDR - 1);
        alloc_n(1, 0);
        check("reinit_first", out_data, 0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 399) == 0);
            fv = ($urandom_range(0, 2) == 0);
            fa = DWIDTH'($urandom_range(0, 63));
            if (fv && m_held.size() > 0 && $urandom_range(0, 9) != 0) begin
                idx = $urandom_range(0, m_held.size() - 1);
                fa  = DWIDTH'(m_held[idx]);
                m_held.delete(idx);
            end
            cycle(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom},
                  ($urandom_range(0, 3) != 0), fv, fa);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pkt_addr_alloc.md
# pkt_addr_alloc

Ingress buffer-address allocator that sits directly upstream of the packet scheduler. It accepts arriving packet headers, pops a free packet-buffer address from an internal free list, and presents header plus address to the scheduler enqueue port as a one-cycle enqueue pulse. Addresses come back from the egress side once a packet has been transmitted and are pushed onto the free list again. The block backpressures ingress when no address is free or the scheduler is not accepting.

## Interface
- `DWIDTH`, 32: width of the address/data word handed to the scheduler.
- `NUM_ADDR`, 16: number of buffer addresses managed. Power of two, 2..1024. `AW = $clog2(NUM_ADDR)` is derived internally.
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `ready` out 1: free-list initialisation is complete.
- `in_valid` in 1: ingress header valid.
- `in_ready` out 1: ingress header accepted this cycle when `in_valid` is also high.
- `in_ugr` in 1: packet is urgent and bypasses priority scheduling.
- `in_pkt_info` in `pkHeadInfo`: header, opaque pass-through.
- `sched_rdy` in 1: scheduler accepts an enqueue this cycle.
- `out_enque_en` out 1: enqueue pulse to the scheduler.
- `out_ugr_en` out 1: urgent flag, qualified by `out_enque_en`.
- `out_pkt_info` out `pkHeadInfo`: registered header.
- `out_data` out `DWIDTH`: allocated address, zero-extended from `AW` bits.
- `free_valid` in 1: return one address.
- `free_addr` in `DWIDTH`: returned address. Only the low `AW` bits are used.
- `free_cnt` out `AW+1`: number of free addresses.
- `free_err` out 1: sticky error flag.

## Operation
- **Storage.** The free list is a circular FIFO: `NUM_ADDR` × `AW`-bit register file, with `rd_ptr`/`wr_ptr` (`AW` bits, natural wrap) and a count `free_cnt` (`AW+1` bits).
- **INIT state** (entered on `rst`):
  - An init counter `k` writes `mem[k] = k` for k = 0..NUM_ADDR-1, one entry per cycle.
  - `wr_ptr` follows `k`.
  - `in_ready = 0`; `free_valid` is ignored and sets `free_err`.
  - After the last write: `rd_ptr = 0`, `wr_ptr` wraps to 0, `free_cnt = NUM_ADDR`, state moves to RUN, `ready = 1`.
- **RUN state:**
  - `in_ready = sched_rdy & (free_cnt != 0)`, computed combinationally from registered state.
  - **Allocate** (`in_valid & in_ready`): register `out_data = mem[rd_ptr]`, `out_pkt_info`, `out_ugr_en = in_ugr`, `out_enque_en = 1`; then `rd_ptr++` and `free_cnt--`.
  - **Free** (`free_valid`): if `free_cnt == NUM_ADDR`, drop the address and set `free_err` (overflow / double free). Otherwise write `mem[wr_ptr] = free_addr[AW-1:0]`, then `wr_ptr++` and `free_cnt++`.
  - **Allocate and free in the same cycle:** both pointers advance and `free_cnt` is unchanged.
    - The allocate reads the pre-write head.
    - When `free_cnt == 0`, `in_ready` is 0 even if a free arrives that cycle; no same-cycle bypass.
  - **Out-of-range `free_addr`:** if any bit above `AW-1` is set, `free_err` is set and the low bits are still pushed.
- **Urgent packets** consume an address exactly like normal packets; only `out_ugr_en` differs.
- **`free_err`** clears only on `rst`.
- **Reset mid-operation:** all in-flight state is discarded, the block returns to INIT, and the free list is fully reinitialised. Addresses held downstream are considered lost.

## Timing
- **Reset values:** `ready = 0`, `in_ready = 0`, `out_enque_en = 0`, `out_ugr_en = 0`, `out_data = 0`, `out_pkt_info = 0`, `free_cnt = 0`, `free_err = 0`.
- **Init duration:** `ready` rises after the NUM_ADDR-th posedge with `rst` low. The first accept is possible on the following edge.
- **Allocate latency:** `out_enque_en` is high the cycle after the accepting edge, for exactly one cycle per accept. Back-to-back accepts give continuous pulses, one address per cycle.
- **Free latency:** `free_cnt` reflects a free one cycle after `free_valid`. A freed address is allocatable no earlier than the next cycle, and in FIFO order.
- **Backpressure:** `sched_rdy` low forces `in_ready` low in the same cycle. No header is ever held or dropped inside the block.

## Test plan
- **Reset/init:** `rst` high 3 cycles, then low → `ready` = 0 for 16 cycles, 1 at cycle 16; `free_cnt` = 16; all outputs 0 during init.
- **Drain:** `in_valid` held high, `sched_rdy` = 1 → 16 pulses with `out_data` 0,1,…,15; then `in_ready` = 0 and `free_cnt` = 0.
- **Recycle:** after drain, free 7 then 3 → next two allocations return 7 then 3; `free_cnt` returns to 0.
- **Simultaneous:** `free_cnt` = 4, allocate and free address 9 in the same cycle → `free_cnt` stays 4; 9 is returned after the 4 older entries.
- **Errors and backpressure:**
  - Free while `free_cnt` = 16 → `free_err` = 1 and sticky; `free_cnt` stays 16.
  - Free during init → `free_err` = 1.
  - `sched_rdy` = 0 with `in_valid` = 1 → no pulse, `free_cnt` unchanged.
- **Urgent and mid-run reset:**
  - `in_ugr` = 1 → `out_ugr_en` = 1 with the address consumed.
  - `rst` pulsed after 5 allocations → full re-init, first allocation afterwards is address 0.
